// File: rtl/instr_encoder_loader.sv
// Encodes symbolic add/sub/or/and/lw/sw/beq beats into RV32I words and writes them sequentially into IMEM.
// Optional feature: define INSTR_NOP_PAD_EN to fill the remaining IMEM words with NOPs before DONE.
module instr_encoder_loader #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WIDTH-1:0]  imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] CAP  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [31:0]     NOP  = 32'h0000_0033;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_PAD   = 2'd3
    } state_t;

    state_t              state_r;
    logic [ADDR_W:0]     ptr_r;
    logic [ADDR_W:0]     count_r;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [WIDTH-1:0]    wdata_r;
    logic                done_r;
    logic                err_r;
    logic                accept_s;
    logic                write_s;
    logic                last_word_s;

    function automatic logic [31:0] encode_op(
        input logic [2:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [12:0] imm
    );
        logic [31:0] w;
        case (op)
            3'd0:    w = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            3'd1:    w = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            3'd2:    w = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
            3'd3:    w = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
            3'd4:    w = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            3'd5:    w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            3'd6:    w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
            default: w = NOP;
        endcase
        return w;
    endfunction

    assign in_ready    = (state_r == ST_LOAD) && (ptr_r < CAP);
    assign accept_s    = in_valid && in_ready;
    assign write_s     = accept_s && (in_op != 3'd7);
    assign last_word_s = (ptr_r == LAST);

    assign imem_we    = we_r;
    assign imem_addr  = addr_r;
    assign imem_wdata = wdata_r;
    assign count      = count_r;
    assign busy       = (state_r != ST_IDLE);
    assign done       = done_r;
    assign err        = err_r;

    // Session FSM with registered write port; ptr counts words issued, count_r counts words completed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            count_r <= '0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            we_r   <= 1'b0;
            done_r <= 1'b0;
            if (we_r) begin
                count_r <= count_r + ONE;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_LOAD;
                        ptr_r   <= '0;
                        count_r <= '0;
                        err_r   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (accept_s && (in_op == 3'd7)) begin
                        err_r <= 1'b1;
                    end
                    if (write_s) begin
                        we_r    <= 1'b1;
                        addr_r  <= ptr_r[ADDR_W-1:0];
                        wdata_r <= encode_op(in_op, in_rd, in_rs1, in_rs2, in_imm);
                        ptr_r   <= ptr_r + ONE;
                    end
                    if (write_s && last_word_s) begin
                        state_r <= ST_DRAIN;
                    end else if (finish) begin
`ifdef INSTR_NOP_PAD_EN
                        state_r <= ST_DRAIN;
`else
                        // A write already in flight completes on this same edge, so only a new one needs DRAIN.
                        if (write_s) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            state_r <= ST_IDLE;
                            done_r  <= 1'b1;
                        end
`endif
                    end
                end
                ST_DRAIN: begin
`ifdef INSTR_NOP_PAD_EN
                    if (ptr_r != CAP) begin
                        state_r <= ST_PAD;
                    end else begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b1;
                    end
`else
                    state_r <= ST_IDLE;
                    done_r  <= 1'b1;
`endif
                end
`ifdef INSTR_NOP_PAD_EN
                ST_PAD: begin
                    we_r    <= 1'b1;
                    addr_r  <= ptr_r[ADDR_W-1:0];
                    wdata_r <= NOP;
                    ptr_r   <= ptr_r + ONE;
                    if (last_word_s) begin
                        state_r <= ST_DRAIN;
                    end
                end
`endif
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader (ADDR_W=2): encoding table, capacity, illegal op, reset.
`timescale 1ns/1ps
module tb_instr_encoder_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          finish = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_op = 3'd0;
    logic [4:0]    in_rd = 5'd0;
    logic [4:0]    in_rs1 = 5'd0;
    logic [4:0]    in_rs2 = 5'd0;
    logic [12:0]   in_imm = 13'd0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic          err;

    instr_encoder_loader #(.WIDTH(32), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [12:0] imm;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    vec_t tbl[11];
    wr_t  sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_ptr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every IMEM write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && imem_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_write", {32'd0, imem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                chk("imem_addr", {62'd0, imem_addr}, {62'd0, e.addr});
                chk("imem_wdata", {32'd0, imem_wdata}, {32'd0, e.data});
            end
        end
    end

    task automatic start_pulse(input bit opens);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (opens) exp_ptr = 0;
    endtask

    task automatic finish_pulse();
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [12:0] imm, input logic [31:0] word);
        bit got;
        wr_t e;
        got = 1'b0;
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                if (op != 3'd7) begin
                    e.addr = exp_ptr[AW-1:0];
                    e.data = word;
                    sb_q.push_back(e);
                    exp_ptr++;
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("send_accepted", {63'd0, got}, 64'd1);
    endtask

    task automatic wait_done(input int exp_count);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (done) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("done_seen", {63'd0, seen}, 64'd1);
        chk("count_at_done", {61'd0, count}, exp_count);
        chk("busy_at_done", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    initial begin
        int acc;
        int n;
        bit saw_done;
        logic [AW:0] cnt_done;
        wr_t e;

        tbl[0]  = '{3'd1, 5'd5, 5'd6, 5'd7, 13'h0000, 32'h407302B3};
        tbl[1]  = '{3'd4, 5'd4, 5'd2, 5'd0, 13'h0008, 32'h00812203};
        tbl[2]  = '{3'd5, 5'd9, 5'd2, 5'd4, 13'h000C, 32'h00412623};
        tbl[3]  = '{3'd0, 5'd3, 5'd1, 5'd2, 13'h0000, 32'h002081B3};
        tbl[4]  = '{3'd6, 5'd0, 5'd1, 5'd2, 13'h1FF8, 32'hFE208CE3};
        tbl[5]  = '{3'd2, 5'd1, 5'd2, 5'd3, 13'h0000, 32'h003160B3};
        tbl[6]  = '{3'd3, 5'd1, 5'd2, 5'd3, 13'h0000, 32'h003170B3};
        tbl[7]  = '{3'd6, 5'd0, 5'd1, 5'd2, 13'h1FF9, 32'hFE208CE3};
        tbl[8]  = '{3'd4, 5'd1, 5'd5, 5'd0, 13'h1FFC, 32'hFFC2A083};
        tbl[9]  = '{3'd5, 5'd0, 5'd0, 5'd31, 13'h1FFF, 32'hFFF02FA3};
        tbl[10] = '{3'd6, 5'd0, 5'd3, 5'd4, 13'h0010, 32'h00418863};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {in_ready, imem_we, done, err, busy, imem_addr, count, imem_wdata},
            {4'd0, 1'b0, {AW{1'b0}}, {(AW+1){1'b0}}, 32'd0});
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", {63'd0, in_ready}, 64'd0);

        // Finish outside LOAD is ignored
        finish_pulse();
        chk("finish_idle_busy", {63'd0, busy}, 64'd0);
        chk("finish_idle_done", {63'd0, done}, 64'd0);

        // Encoding table in sessions of up to four words
        for (int i = 0; i < 11; i++) begin
            if (i % 4 == 0) begin
                start_pulse(1'b1);
                chk("busy_after_start", {63'd0, busy}, 64'd1);
            end
            send(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].word);
            if (i % 4 == 3) begin
                wait_done(4);
            end else if (i == 10) begin
                finish_pulse();
                wait_done(3);
            end
        end

        // Empty session: DONE the cycle after FINISH
        start_pulse(1'b1);
        finish_pulse();
        chk("empty_done", {63'd0, done}, 64'd1);
        chk("empty_count", {61'd0, count}, 64'd0);
        @(posedge clk); #1;
        chk("empty_done_pulse", {63'd0, done}, 64'd0);

        // FINISH together with an accepted beat: write lands, then DONE
        start_pulse(1'b1);
        in_valid = 1'b1; in_op = 3'd0; in_rd = 5'd3; in_rs1 = 5'd1; in_rs2 = 5'd2; in_imm = 13'd0;
        finish = 1'b1;
        @(negedge clk);
        chk("fin_acc_ready", {63'd0, in_ready}, 64'd1);
        e.addr = exp_ptr[AW-1:0]; e.data = 32'h002081B3; sb_q.push_back(e); exp_ptr++;
        @(posedge clk); #1;
        in_valid = 1'b0; finish = 1'b0;
        chk("fin_acc_we_latency", {63'd0, imem_we}, 64'd1);
        chk("fin_acc_no_early_done", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        chk("fin_acc_done", {63'd0, done}, 64'd1);
        chk("fin_acc_count", {61'd0, count}, 64'd1);
        chk("fin_acc_we_off", {63'd0, imem_we}, 64'd0);

        // START inside LOAD is ignored; illegal op sets sticky ERR, writes nothing
        start_pulse(1'b1);
        send(3'd0, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3);
        start_pulse(1'b0);
        send(3'd7, 5'd1, 5'd1, 5'd1, 13'd0, 32'd0);
        chk("err_set", {63'd0, err}, 64'd1);
        send(3'd0, 5'd3, 5'd1, 5'd2, 13'd0, 32'h002081B3);
        finish_pulse();
        wait_done(2);
        chk("err_sticky", {63'd0, err}, 64'd1);

        // Capacity: valid held, five beats offered, four accepted
        start_pulse(1'b1);
        chk("err_cleared", {63'd0, err}, 64'd0);
        in_valid = 1'b1; in_op = 3'd0; in_rd = 5'd1; in_rs1 = 5'd1; in_rs2 = 5'd1; in_imm = 13'd0;
        acc = 0; saw_done = 1'b0; cnt_done = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (in_ready && acc < 5) begin
                e.addr = exp_ptr[AW-1:0]; e.data = 32'h001080B3; sb_q.push_back(e);
                exp_ptr++; acc++;
            end
            @(posedge clk); #1;
            if (done) begin
                saw_done = 1'b1;
                cnt_done = count;
            end
        end
        in_valid = 1'b0;
        chk("cap_accepts", acc, 64'd4);
        chk("cap_done", {63'd0, saw_done}, 64'd1);
        chk("cap_count", {61'd0, cnt_done}, 64'd4);
        chk("cap_ready_low", {63'd0, in_ready}, 64'd0);

        // Reset asserted right after an accept drops the in-flight write
        start_pulse(1'b1);
        send(3'd1, 5'd5, 5'd6, 5'd7, 13'd0, 32'h407302B3);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        chk("rst_mid_outputs", {in_ready, imem_we, done, err, busy, imem_addr, count, imem_wdata},
            {4'd0, 1'b0, {AW{1'b0}}, {(AW+1){1'b0}}, 32'd0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (imem_we) n++;
        end
        chk("rst_no_write", n, 64'd0);

        chk("sb_empty", sb_q.size(), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
